// File: rtl/arb_output_stage_if.sv
// Consumer-side handshake of arb_output_stage.
//   out_valid : head entry valid
//   out_ready : consumer accepts head when out_valid && out_ready
//   out_data  : head entry data word
//   out_tag   : binary index of the FIFO that supplied the head entry
// master drives valid/data/tag (the stage); slave drives ready (the consumer).
interface arb_output_stage_if #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned TAGWIDTH = 2
);
  logic                out_valid;
  logic                out_ready;
  logic [WIDTH-1:0]    out_data;
  logic [TAGWIDTH-1:0] out_tag;

  modport master (
    output out_valid,
    output out_data,
    output out_tag,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_data,
    input  out_tag,
    output out_ready
  );
endinterface

// File: rtl/arb_output_stage.sv
// Output stage of the arbitrated FIFO bank.
// Captures the word popped on each one-hot grant together with the encoded grant index, keeps
// them in a 2-entry in-order buffer and presents the head over out_if (valid/ready). Requests to
// the arbiter are masked while the buffer is full. Illegal grants set a sticky error flag.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   reqs_in    : raw per-source requests
//   reqs_out   : requests forwarded to the arbiter, masked when the buffer is full
//   gnt        : arbiter grant (one-hot or zero), data_in valid when non-zero
//   data_in    : arbiter mux output
//   count      : buffer occupancy 0..2
//   gnt_err    : sticky protocol error (multi-bit grant, or grant while full)
//   out_if     : head entry handshake (master side)
module arb_output_stage #(
  parameter int unsigned NUM_FIFOS = 4,
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned TAGWIDTH  = (NUM_FIFOS > 1) ? $clog2(NUM_FIFOS) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_FIFOS-1:0] reqs_in,
  output logic [NUM_FIFOS-1:0] reqs_out,
  input  logic [NUM_FIFOS-1:0] gnt,
  input  logic [WIDTH-1:0]     data_in,
  output logic [1:0]           count,
  output logic                 gnt_err,
  arb_output_stage_if.master   out_if
);

  logic [1:0]          count_q, count_d;
  logic                valid_q, valid_d;
  logic                err_q, err_d;
  logic [WIDTH-1:0]    head_data_q, head_data_d, tail_data_q, tail_data_d;
  logic [TAGWIDTH-1:0] head_tag_q, head_tag_d, tail_tag_q, tail_tag_d;

  logic                space;
  logic                gnt_any;
  logic                gnt_onehot;
  logic [TAGWIDTH-1:0] gnt_tag;
  logic                push;
  logic                pop;

  // Uses only the registered count so neither gnt nor out_ready reaches reqs_out.
  assign space    = (count_q < 2'd2);
  assign reqs_out = reqs_in & {NUM_FIFOS{space}};

  assign gnt_any    = (gnt != '0);
  assign gnt_onehot = gnt_any && ((gnt & (gnt - NUM_FIFOS'(1))) == '0);
  assign push       = gnt_onehot && space;
  assign pop        = valid_q && out_if.out_ready;

  always_comb begin
    gnt_tag = '0;
    for (int unsigned i = 0; i < NUM_FIFOS; i++) begin
      if (gnt[i]) gnt_tag = TAGWIDTH'(i);
    end
  end

  always_comb begin
    count_d     = count_q;
    head_data_d = head_data_q;
    head_tag_d  = head_tag_q;
    tail_data_d = tail_data_q;
    tail_tag_d  = tail_tag_q;
    case (count_q)
      2'd0: begin
        if (push) begin
          head_data_d = data_in;
          head_tag_d  = gnt_tag;
          count_d     = 2'd1;
        end
      end
      2'd1: begin
        if (push && pop) begin
          // Head leaves and the new word takes its place in the same cycle.
          head_data_d = data_in;
          head_tag_d  = gnt_tag;
        end else if (push) begin
          tail_data_d = data_in;
          tail_tag_d  = gnt_tag;
          count_d     = 2'd2;
        end else if (pop) begin
          // Head register keeps its last value while empty.
          count_d = 2'd0;
        end
      end
      2'd2: begin
        if (pop) begin
          head_data_d = tail_data_q;
          head_tag_d  = tail_tag_q;
          count_d     = 2'd1;
        end
      end
      default: count_d = 2'd0;
    endcase
    valid_d = (count_d != 2'd0);
    err_d   = err_q || (gnt_any && (!gnt_onehot || !space));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q     <= 2'd0;
      valid_q     <= 1'b0;
      err_q       <= 1'b0;
      head_data_q <= '0;
      head_tag_q  <= '0;
      tail_data_q <= '0;
      tail_tag_q  <= '0;
    end else begin
      count_q     <= count_d;
      valid_q     <= valid_d;
      err_q       <= err_d;
      head_data_q <= head_data_d;
      head_tag_q  <= head_tag_d;
      tail_data_q <= tail_data_d;
      tail_tag_q  <= tail_tag_d;
    end
  end

  assign count            = count_q;
  assign gnt_err          = err_q;
  assign out_if.out_valid = valid_q;
  assign out_if.out_data  = head_data_q;
  assign out_if.out_tag   = head_tag_q;

endmodule

// File: tb/tb_arb_output_stage.sv
module tb_arb_output_stage;
  localparam int unsigned NF = 4;
  localparam int unsigned W  = 8;
  localparam int unsigned TW = 2;

  logic          clk   = 1'b0;
  logic          rst_n = 1'b0;
  logic [NF-1:0] reqs_in = '0;
  logic [NF-1:0] reqs_out;
  logic [NF-1:0] gnt = '0;
  logic [W-1:0]  data_in = '0;
  logic [1:0]    count;
  logic          gnt_err;

  arb_output_stage_if #(.WIDTH(W), .TAGWIDTH(TW)) out_if ();

  arb_output_stage #(
    .NUM_FIFOS(NF),
    .WIDTH    (W),
    .TAGWIDTH (TW)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .reqs_in (reqs_in),
    .reqs_out(reqs_out),
    .gnt     (gnt),
    .data_in (data_in),
    .count   (count),
    .gnt_err (gnt_err),
    .out_if  (out_if.master)
  );

  always #5 clk = ~clk;

  // Reference model: a queue of pending words plus the last value shown at the head.
  typedef struct packed {
    logic [W-1:0]  data;
    logic [TW-1:0] tag;
  } entry_t;

  entry_t mq[$];
  entry_t m_head;
  logic   m_err;

  int n_vec = 0;
  int n_bad = 0;

  typedef struct {
    logic [NF-1:0] r;
    logic [NF-1:0] g;
    logic [W-1:0]  d;
    logic          rdy;
    logic [NF-1:0] exp_ro;
    logic          exp_v;
    logic [W-1:0]  exp_d;
    logic [TW-1:0] exp_t;
    logic [1:0]    exp_c;
  } vec_t;

  vec_t tbl[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [TW-1:0] idx_of(input logic [NF-1:0] g);
    for (int i = 0; i < int'(NF); i++) if (g[i]) return TW'(i);
    return '0;
  endfunction

  task automatic model_reset();
    mq.delete();
    m_head = '0;
    m_err  = 1'b0;
  endtask

  task automatic model_clock(input logic [NF-1:0] g, input logic [W-1:0] d, input logic rdy);
    int     n;
    bit     space;
    bit     legal;
    entry_t e;
    n     = mq.size();
    space = (n < 2);
    legal = ($countones(g) == 1);
    if (g != '0 && (!legal || !space)) m_err = 1'b1;
    if (n > 0 && rdy) void'(mq.pop_front());
    if (legal && space) begin
      e.data = d;
      e.tag  = idx_of(g);
      mq.push_back(e);
    end
    if (mq.size() > 0) m_head = mq[0];
  endtask

  task automatic check_model();
    chk("out_valid", out_if.out_valid, (mq.size() != 0));
    chk("out_data", out_if.out_data, m_head.data);
    chk("out_tag", out_if.out_tag, m_head.tag);
    chk("count", count, mq.size());
    chk("gnt_err", gnt_err, m_err);
  endtask

  // Called at posedge+1; leaves at the next posedge+1.
  task automatic step(input logic [NF-1:0] r, input logic [NF-1:0] g, input logic [W-1:0] d,
                      input logic rdy, output logic [NF-1:0] ro_seen);
    reqs_in          = r;
    gnt              = g;
    data_in          = d;
    out_if.out_ready = rdy;
    #1;
    ro_seen = reqs_out;
    chk("reqs_out", reqs_out, (mq.size() < 2) ? r : '0);
    @(posedge clk);
    model_clock(g, d, rdy);
    #1;
    check_model();
  endtask

  task automatic async_reset();
    #3;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("rst_valid", out_if.out_valid, 1'b0);
    chk("rst_count", count, 2'd0);
    chk("rst_err", gnt_err, 1'b0);
    chk("rst_data", out_if.out_data, '0);
    chk("rst_tag", out_if.out_tag, '0);
    chk("rst_reqs_out", reqs_out, reqs_in);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    logic [NF-1:0] ro;
    logic [NF-1:0] g;
    int            k;

    tbl[0] = '{4'hF, 4'b0100, 8'hA5, 1'b1, 4'hF, 1'b1, 8'hA5, 2'd2, 2'd1};
    tbl[1] = '{4'hA, 4'b0000, 8'h00, 1'b1, 4'hA, 1'b0, 8'hA5, 2'd2, 2'd0};
    tbl[2] = '{4'hF, 4'b0001, 8'h11, 1'b0, 4'hF, 1'b1, 8'h11, 2'd0, 2'd1};
    tbl[3] = '{4'h5, 4'b1000, 8'h22, 1'b0, 4'h5, 1'b1, 8'h11, 2'd0, 2'd2};
    tbl[4] = '{4'hF, 4'b0000, 8'h00, 1'b0, 4'h0, 1'b1, 8'h11, 2'd0, 2'd2};
    tbl[5] = '{4'hF, 4'b0000, 8'h00, 1'b1, 4'h0, 1'b1, 8'h22, 2'd3, 2'd1};
    tbl[6] = '{4'hF, 4'b0000, 8'h00, 1'b1, 4'hF, 1'b0, 8'h22, 2'd3, 2'd0};
    tbl[7] = '{4'hF, 4'b0001, 8'h33, 1'b0, 4'hF, 1'b1, 8'h33, 2'd0, 2'd1};
    tbl[8] = '{4'h3, 4'b0010, 8'h44, 1'b1, 4'h3, 1'b1, 8'h44, 2'd1, 2'd1};
    tbl[9] = '{4'hF, 4'b0000, 8'h00, 1'b1, 4'hF, 1'b0, 8'h44, 2'd1, 2'd0};

    out_if.out_ready = 1'b0;
    reqs_in          = 4'b1011;
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("init_valid", out_if.out_valid, 1'b0);
    chk("init_count", count, 2'd0);
    chk("init_err", gnt_err, 1'b0);
    chk("init_data", out_if.out_data, '0);
    chk("init_tag", out_if.out_tag, '0);
    chk("init_reqs_out", reqs_out, 4'b1011);
    rst_n = 1'b1;

    // Directed table: single grant, fill/backpressure/drain, simultaneous push+pop.
    foreach (tbl[i]) begin
      step(tbl[i].r, tbl[i].g, tbl[i].d, tbl[i].rdy, ro);
      chk($sformatf("tbl%0d_reqs_out", i), ro, tbl[i].exp_ro);
      chk($sformatf("tbl%0d_valid", i), out_if.out_valid, tbl[i].exp_v);
      chk($sformatf("tbl%0d_data", i), out_if.out_data, tbl[i].exp_d);
      chk($sformatf("tbl%0d_tag", i), out_if.out_tag, tbl[i].exp_t);
      chk($sformatf("tbl%0d_count", i), count, tbl[i].exp_c);
      chk($sformatf("tbl%0d_err", i), gnt_err, 1'b0);
    end

    // Back-to-back stream with the consumer always ready.
    for (int i = 0; i < 16; i++) begin
      step(4'hF, NF'(1) << (i % 4), 8'(i * 7 + 1), 1'b1, ro);
      chk("stream_data", out_if.out_data, 8'(i * 7 + 1));
      chk("stream_count_le1", (count <= 2'd1), 1'b1);
      chk("stream_no_err", gnt_err, 1'b0);
    end
    step(4'hF, 4'b0000, 8'h00, 1'b1, ro);

    // Multi-bit grant: nothing captured, sticky error.
    step(4'hF, 4'b0110, 8'h77, 1'b1, ro);
    chk("multi_err", gnt_err, 1'b1);
    chk("multi_count", count, 2'd0);
    for (int i = 0; i < 3; i++) step(4'hF, 4'b0000, 8'h00, 1'b0, ro);
    chk("multi_err_sticky", gnt_err, 1'b1);
    async_reset();

    // Grant while full: word dropped even though the head pops this cycle.
    step(4'hF, 4'b0001, 8'h81, 1'b0, ro);
    step(4'hF, 4'b0010, 8'h82, 1'b0, ro);
    step(4'hF, 4'b0001, 8'h83, 1'b1, ro);
    chk("drop_err", gnt_err, 1'b1);
    chk("drop_count", count, 2'd1);
    chk("drop_head", out_if.out_data, 8'h82);
    step(4'hF, 4'b0100, 8'h84, 1'b0, ro);
    chk("drop_refill_count", count, 2'd2);
    chk("drop_err_sticky", gnt_err, 1'b1);

    // Asynchronous reset with a full buffer, then a fresh grant.
    async_reset();
    step(4'hF, 4'b1000, 8'h5A, 1'b1, ro);
    chk("post_rst_valid", out_if.out_valid, 1'b1);
    chk("post_rst_data", out_if.out_data, 8'h5A);
    chk("post_rst_tag", out_if.out_tag, 2'd3);
    chk("post_rst_count", count, 2'd1);
    step(4'hF, 4'b0000, 8'h00, 1'b1, ro);
    chk("post_rst_empty", count, 2'd0);

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      k = int'($urandom_range(0, 49));
      if (mq.size() == 2 && k != 0) g = '0;
      else if (k < 15) g = '0;
      else if (k == 49) g = NF'($urandom);
      else g = NF'(1) << $urandom_range(0, NF - 1);
      step(NF'($urandom), g, W'($urandom), 1'($urandom_range(0, 1)), ro);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
